clap_detect: RTL and testbench

- Upstream stage of the mode-cycling state logic: turns a microphone amplitude stream into the one-cycle `clap_set` qualifier that state logic samples on each clock.
- Detects a double clap: two above-threshold samples separated by a blanking interval and falling inside a bounded window.
- Blanking rejects ringing from a single clap. The window rejects isolated noise spikes.

---
 rtl/clap_detect.sv | 99 +++++++++
 tb/tb_clap_detect.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clap_detect.sv
// Double-clap qualifier: flags two loud samples that are separated by a blanking gap and fall inside a bounded window.
// Latency: clap_set_o pulses one cycle after the second hit is sampled; there is no backpressure and samples are taken whenever valid.
module clap_detect #(
    parameter int W             = 12,
    parameter int THRESH        = 1024,
    parameter int BLANK_CYCLES  = 5000000,
    parameter int WINDOW_CYCLES = 40000000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] sample_i,
    input  logic         sample_valid_i,
    output logic         clap_set_o,
    output logic         armed_o,
    output logic [1:0]   state_o
);

    localparam int MAXC = (BLANK_CYCLES > WINDOW_CYCLES) ? BLANK_CYCLES : WINDOW_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] WIN_LOAD   = CW'(WINDOW_CYCLES - 1);
    localparam logic [W-1:0]  TH         = W'(THRESH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK1 = 2'd1,
        WAIT2  = 2'd2,
        BLANK2 = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_clap;
    logic          r_armed;
    logic [W-1:0]  w_mag;
    logic          w_hit;

    // Two's-complement negate of the most negative code yields 2^(W-1) as an unsigned value.
    assign w_mag = sample_i[W-1] ? ((~sample_i) + W'(1)) : sample_i;
    assign w_hit = sample_valid_i & (w_mag >= TH);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_clap  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_clap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state <= BLANK1;
                        r_cnt   <= BLANK_LOAD;
                        r_armed <= 1'b1;
                    end
                end
                BLANK1: begin
                    if (r_cnt == '0) begin
                        r_state <= WAIT2;
                        r_cnt   <= WIN_LOAD;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                WAIT2: begin
                    // A hit on the final window cycle still counts.
                    if (w_hit) begin
                        r_state <= BLANK2;
                        r_cnt   <= BLANK_LOAD;
                        r_clap  <= 1'b1;
                        r_armed <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_armed <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                BLANK2: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign clap_set_o = r_clap;
    assign armed_o    = r_armed;
    assign state_o    = r_state;

endmodule

// File: tb/tb_clap_detect.sv
// Bench for clap_detect: directed scenarios with literal expectations plus a randomized run,
// all cross-checked each cycle against a timestamp-based model of the clap timeline.
module tb_clap_detect;

    localparam int W  = 12;
    localparam int B  = 4;
    localparam int WN = 10;

    logic          clk;
    logic          rst;
    logic [W-1:0]  sample;
    logic          valid;
    logic          clap_set;
    logic          armed;
    logic [1:0]    state;

    int n_tests = 0;
    int n_fail  = 0;

    clap_detect #(.W(W), .THRESH(1024), .BLANK_CYCLES(B), .WINDOW_CYCLES(WN)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_i       (sample),
        .sample_valid_i (valid),
        .clap_set_o     (clap_set),
        .armed_o        (armed),
        .state_o        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remembers the edge of the first and second clap and derives the phase by elapsed time.
    int n    = 0;
    bit has_f = 0;
    bit has_s = 0;
    int f_e  = 0;
    int s_e  = 0;
    int exp_state = 0;
    bit exp_pulse = 0;
    bit exp_armed = 0;
    bit chk_en    = 0;

    function automatic int phase_at(int k);
        if (has_s && (k - s_e) >= 0 && (k - s_e) < B) return 3;
        if (has_f && (k - f_e) >= 0 && (k - f_e) < B) return 1;
        if (has_f && !has_s && (k - f_e) >= B && (k - f_e) < B + WN) return 2;
        return 0;
    endfunction

    function automatic bit is_hit(logic v, logic [W-1:0] s);
        int sv;
        sv = int'($signed(s));
        if (sv < 0) sv = -sv;
        return v && (sv >= 1024);
    endfunction

    task automatic model_edge(logic r, logic v, logic [W-1:0] s);
        int pre;
        bit h;
        pre = phase_at(n - 1);
        h = is_hit(v, s);
        exp_pulse = 1'b0;
        if (r) begin
            has_f = 0;
            has_s = 0;
        end else if (pre == 0 && h) begin
            has_f = 1;
            f_e   = n;
            has_s = 0;
        end else if (pre == 2 && h) begin
            has_s = 1;
            s_e   = n;
            exp_pulse = 1'b1;
        end
        exp_state = phase_at(n);
        exp_armed = (exp_state == 1) || (exp_state == 2);
        n++;
    endtask

    task automatic chk(string nm, int act, int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model clap_set", int'(clap_set), int'(exp_pulse));
            chk("model armed", int'(armed), int'(exp_armed));
            chk("model state", int'(state), exp_state);
        end
    end

    task automatic step(logic r, logic v, logic [W-1:0] s);
        @(negedge clk);
        rst    = r;
        valid  = v;
        sample = s;
        @(posedge clk);
        model_edge(r, v, s);
    endtask

    task automatic quiet(int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b1, 12'd0);
    endtask

    task automatic hit();
        step(1'b0, 1'b1, 12'd1500);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 12'd0);
    endtask

    task automatic thr(string nm, logic v, logic [W-1:0] s, int req_state);
        do_reset();
        step(1'b0, v, s);
        #1 chk(nm, int'(state), req_state);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; sample = '0;
        do_reset();
        chk_en = 1'b1;
        #1;
        chk("reset state", int'(state), 0);
        chk("reset clap", int'(clap_set), 0);
        chk("reset armed", int'(armed), 0);

        // Single hit, then quiet
        hit();
        #1 chk("single blank1", int'(state), 1);
        chk("single armed", int'(armed), 1);
        quiet(13);
        #1 chk("single wait2 end", int'(state), 2);
        quiet(1);
        #1 chk("single idle", int'(state), 0);
        chk("single armed off", int'(armed), 0);

        // Double clap at t and t+6
        hit(); quiet(5); hit();
        #1 chk("double pulse", int'(clap_set), 1);
        chk("double blank2", int'(state), 3);
        quiet(1);
        #1 chk("double pulse once", int'(clap_set), 0);
        quiet(3);
        #1 chk("double idle", int'(state), 0);

        // Second hit inside the blank is ignored
        hit(); quiet(2); hit(); quiet(11);
        #1 chk("blank ignore idle", int'(state), 0);

        // Window edges
        hit(); quiet(13); hit();
        #1 chk("window last pulse", int'(clap_set), 1);
        quiet(4);
        hit(); quiet(14); hit();
        #1 chk("window late nopulse", int'(clap_set), 0);
        chk("window late blank1", int'(state), 1);

        // Threshold and sign
        thr("thr 1024", 1'b1, 12'd1024, 1);
        thr("thr -1024", 1'b1, 12'hC00, 1);
        thr("thr -2048", 1'b1, 12'h800, 1);
        thr("thr 1023", 1'b1, 12'd1023, 0);
        thr("thr -1023", 1'b1, 12'hC01, 0);
        thr("thr invalid", 1'b0, 12'd2047, 0);

        // Reset during WAIT2, then a fresh first clap
        do_reset();
        hit(); quiet(6); do_reset();
        #1 chk("rst mid idle", int'(state), 0);
        quiet(1); hit();
        #1 chk("rst mid nopulse", int'(clap_set), 0);
        chk("rst mid blank1", int'(state), 1);

        // Reset and hit on the same edge
        do_reset();
        step(1'b1, 1'b1, 12'd1500);
        #1 chk("rst+hit idle", int'(state), 0);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] s;
            logic v, r;
            int sel;
            sel = $urandom_range(0, 15);
            if (sel < 2)       s = 12'(1024 + $urandom_range(0, 1023));
            else if (sel < 4)  s = 12'(-(1024 + int'($urandom_range(0, 1024))));
            else if (sel == 4) s = 12'd1023;
            else if (sel == 5) s = 12'hC01;
            else               s = 12'($urandom_range(0, 600));
            v = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 299) == 0);
            step(r, v, s);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
